// File: rtl/aritmetica_pipe_if.sv
// Sample/result bus of the multiply-add pipeline: source drives samples, unit returns results.
interface aritmetica_pipe_if #(
  parameter int W = 24
);
  logic                In_valid;
  logic                Acum_en;
  logic                Acum_clr;
  logic signed [W-1:0] Constantes_G;
  logic signed [W-1:0] Multip_G;
  logic signed [W-1:0] Entrada_G;
  logic signed [W-1:0] Valores;
  logic                Out_valid;
  logic                Sat;
  logic                Sat_sticky;

  modport master (
    output In_valid, Acum_en, Acum_clr, Constantes_G, Multip_G, Entrada_G,
    input  Valores, Out_valid, Sat, Sat_sticky
  );

  modport slave (
    input  In_valid, Acum_en, Acum_clr, Constantes_G, Multip_G, Entrada_G,
    output Valores, Out_valid, Sat, Sat_sticky
  );
endinterface

// File: rtl/aritmetica_pipe.sv
// Three-stage signed fixed-point multiply-add with saturation and an accumulate mode
// that feeds the result register back as the addend.
module aritmetica_pipe #(
  parameter int W    = 24,
  parameter int FRAC = 10
) (
  input  logic              CLK,
  input  logic              RST,
  aritmetica_pipe_if.slave  bus
);
  localparam int PW = 2 * W - FRAC;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] SMAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  // Returns {clamped, value}.
  function automatic logic [W:0] sat_clamp(input logic signed [SW-1:0] s);
    if (s > SMAX)      return {1'b1, 1'b0, {(W-1){1'b1}}};
    else if (s < SMIN) return {1'b1, 1'b1, {(W-1){1'b0}}};
    else               return {1'b0, s[W-1:0]};
  endfunction

  logic                 vld_p1_q, vld_p1_d, en_p1_q, en_p1_d, clr_p1_q, clr_p1_d;
  logic signed [W-1:0]  c_p1_q, c_p1_d, m_p1_q, m_p1_d, e_p1_q, e_p1_d;
  logic                 vld_p2_q, vld_p2_d, en_p2_q, en_p2_d, clr_p2_q, clr_p2_d;
  logic signed [W-1:0]  c_p2_q, c_p2_d;
  logic signed [PW-1:0] p_p2_q, p_p2_d;
  logic                 vld_p3_q, vld_p3_d, sat_q, sat_d, sticky_q, sticky_d;
  logic signed [W-1:0]  valores_q, valores_d;

  logic signed [2*W-1:0] prod;
  logic signed [W-1:0]   addend;
  logic signed [SW-1:0]  sum;
  logic [W:0]            clamp;

  always_comb begin
    vld_p1_d  = bus.In_valid;
    en_p1_d   = en_p1_q;
    clr_p1_d  = clr_p1_q;
    c_p1_d    = c_p1_q;
    m_p1_d    = m_p1_q;
    e_p1_d    = e_p1_q;
    vld_p2_d  = vld_p1_q;
    en_p2_d   = en_p2_q;
    clr_p2_d  = clr_p2_q;
    c_p2_d    = c_p2_q;
    p_p2_d    = p_p2_q;
    vld_p3_d  = vld_p2_q;
    valores_d = valores_q;
    sat_d     = sat_q;
    sticky_d  = sticky_q;

    // Stage 1: capture a sample only when it is strobed.
    if (bus.In_valid) begin
      en_p1_d  = bus.Acum_en;
      clr_p1_d = bus.Acum_clr;
      c_p1_d   = bus.Constantes_G;
      m_p1_d   = bus.Multip_G;
      e_p1_d   = bus.Entrada_G;
    end

    // Stage 2: full-precision product, floor-shifted back to the data scale.
    prod = m_p1_q * e_p1_q;
    if (vld_p1_q) begin
      p_p2_d   = PW'(prod >>> FRAC);
      c_p2_d   = c_p1_q;
      en_p2_d  = en_p1_q;
      clr_p2_d = clr_p1_q;
    end

    // Stage 3: add against the result register itself so back-to-back sums chain.
    addend = en_p2_q ? (clr_p2_q ? '0 : valores_q) : c_p2_q;
    sum    = SW'(addend) + SW'(p_p2_q);
    clamp  = sat_clamp(sum);
    if (vld_p2_q) begin
      valores_d = clamp[W-1:0];
      sat_d     = clamp[W];
      sticky_d  = (clr_p2_q ? 1'b0 : sticky_q) | clamp[W];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1_q  <= 1'b0;
      en_p1_q   <= 1'b0;
      clr_p1_q  <= 1'b0;
      c_p1_q    <= '0;
      m_p1_q    <= '0;
      e_p1_q    <= '0;
      vld_p2_q  <= 1'b0;
      en_p2_q   <= 1'b0;
      clr_p2_q  <= 1'b0;
      c_p2_q    <= '0;
      p_p2_q    <= '0;
      vld_p3_q  <= 1'b0;
      valores_q <= '0;
      sat_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      en_p1_q   <= en_p1_d;
      clr_p1_q  <= clr_p1_d;
      c_p1_q    <= c_p1_d;
      m_p1_q    <= m_p1_d;
      e_p1_q    <= e_p1_d;
      vld_p2_q  <= vld_p2_d;
      en_p2_q   <= en_p2_d;
      clr_p2_q  <= clr_p2_d;
      c_p2_q    <= c_p2_d;
      p_p2_q    <= p_p2_d;
      vld_p3_q  <= vld_p3_d;
      valores_q <= valores_d;
      sat_q     <= sat_d;
      sticky_q  <= sticky_d;
    end
  end

  assign bus.Valores    = valores_q;
  assign bus.Out_valid  = vld_p3_q;
  assign bus.Sat        = sat_q;
  assign bus.Sat_sticky = sticky_q;
endmodule

// File: tb/tb_aritmetica_pipe.sv
// Randomized bench for aritmetica_pipe against a sample-order arithmetic reference model.
module tb_aritmetica_pipe;
  localparam int W    = 24;
  localparam int FRAC = 10;
  localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W-1));

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  aritmetica_pipe_if #(.W(W)) bus ();

  aritmetica_pipe #(.W(W), .FRAC(FRAC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit     v;
    longint val;
    bit     sat;
    bit     sticky;
  } res_t;

  res_t   pipe_q[$];
  longint m_acc;
  bit     m_sticky;
  longint e_val;
  bit     e_sat, e_sticky, e_ov;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    res_t z;
    z = '{default: 0};
    pipe_q = {};
    pipe_q.push_back(z);
    pipe_q.push_back(z);
    m_acc = 0; m_sticky = 0;
    e_val = 0; e_sat = 0; e_sticky = 0; e_ov = 0;
  endtask

  function automatic longint rnd_w();
    logic signed [W-1:0] t;
    t = W'($urandom);
    return t;
  endfunction

  // Drives one cycle, updates the model at the accepting edge, checks outputs #1 later.
  task automatic step(input bit v, input bit en, input bit clr,
                      input longint c, input longint m, input longint e);
    res_t r;
    longint p, s, a;
    bus.In_valid     = v;
    bus.Acum_en      = en;
    bus.Acum_clr     = clr;
    bus.Constantes_G = c[W-1:0];
    bus.Multip_G     = m[W-1:0];
    bus.Entrada_G    = e[W-1:0];
    @(posedge CLK);
    r = '{default: 0};
    r.v = v;
    if (v) begin
      p = (m * e) >>> FRAC;
      a = en ? (clr ? 0 : m_acc) : c;
      s = a + p;
      if (s > MAXV)      begin r.val = MAXV; r.sat = 1; end
      else if (s < MINV) begin r.val = MINV; r.sat = 1; end
      else               begin r.val = s;    r.sat = 0; end
      if (clr) m_sticky = 0;
      m_sticky = m_sticky | r.sat;
      r.sticky = m_sticky;
      m_acc = r.val;
    end
    pipe_q.push_back(r);
    r = pipe_q.pop_front();
    e_ov = r.v;
    if (r.v) begin
      e_val = r.val; e_sat = r.sat; e_sticky = r.sticky;
    end
    #1;
    chk("out_valid", bus.Out_valid, e_ov);
    chk("valores", bus.Valores, e_val);
    chk("sat", bus.Sat, e_sat);
    chk("sat_sticky", bus.Sat_sticky, e_sticky);
  endtask

  task automatic idle();
    step(0, 1'($urandom), 1'($urandom), rnd_w(), rnd_w(), rnd_w());
  endtask

  task automatic run_one(input longint c, input longint m, input longint e);
    step(1, 0, 0, c, m, e);
    idle();
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt, pulse_cnt, mode;
    bit v, en, clr;
    longint c, m, e;

    RST = 1'b1;
    bus.In_valid = 0; bus.Acum_en = 0; bus.Acum_clr = 0;
    bus.Constantes_G = '0; bus.Multip_G = '0; bus.Entrada_G = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valores", bus.Valores, 0);
    chk("rst_out_valid", bus.Out_valid, 0);
    chk("rst_sat", bus.Sat, 0);
    chk("rst_sticky", bus.Sat_sticky, 0);
    @(negedge CLK);
    RST = 1'b0;

    step(1, 0, 0, 5, 1024, 300);
    idle();
    idle();
    chk("basic_val", bus.Valores, 305);
    chk("basic_ov", bus.Out_valid, 1);
    chk("basic_sat", bus.Sat, 0);
    idle();
    chk("basic_pulse_end", bus.Out_valid, 0);

    run_one(0, -1024, 300);  chk("neg", bus.Valores, -300);
    run_one(0, 1, 1);        chk("trunc_zero", bus.Valores, 0);
    run_one(0, -1, 1);       chk("floor_neg", bus.Valores, -1);
    run_one(MAXV, MAXV, MAXV);
    chk("satp_val", bus.Valores, MAXV);
    chk("satp_sat", bus.Sat, 1);
    chk("satp_sticky", bus.Sat_sticky, 1);
    run_one(MINV, MAXV, MINV);
    chk("satn_val", bus.Valores, MINV);
    chk("satn_sat", bus.Sat, 1);
    run_one(1, 0, 0);
    chk("norm_val", bus.Valores, 1);
    chk("norm_sat", bus.Sat, 0);
    chk("norm_sticky", bus.Sat_sticky, 1);

    step(1, 1, 1, 0, 1024, 100);
    step(1, 1, 0, 0, 1024, 50);
    step(1, 1, 0, 0, 1024, -200);
    chk("acc_clr", bus.Valores, 100);
    chk("acc_clr_sticky", bus.Sat_sticky, 0);
    step(1, 0, 0, 7, 0, 0);
    chk("acc_add", bus.Valores, 150);
    idle();
    chk("acc_neg", bus.Valores, -50);
    idle();
    chk("acc_const", bus.Valores, 7);

    acc_cnt = 0;
    pulse_cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      en   = 1'($urandom);
      clr  = ($urandom_range(0, 7) == 0);
      mode = $urandom_range(0, 2);
      c = rnd_w();
      m = rnd_w();
      e = rnd_w();
      if (mode == 1) m = $signed($urandom_range(0, 4095)) - 2048;
      if (mode == 2) begin
        m = $signed($urandom_range(0, 4095)) - 2048;
        e = $signed($urandom_range(0, 65535)) - 32768;
        c = $signed($urandom_range(0, 65535)) - 32768;
      end
      step(v, en, clr, c, m, e);
      if (v) acc_cnt++;
      if (bus.Out_valid) pulse_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      if (bus.Out_valid) pulse_cnt++;
    end
    chk("pulse_count", pulse_cnt, acc_cnt);

    step(1, 0, 0, 3, 1024, 1);
    step(1, 0, 0, 4, 1024, 2);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_valores", bus.Valores, 0);
    chk("arst_out_valid", bus.Out_valid, 0);
    chk("arst_sat", bus.Sat, 0);
    chk("arst_sticky", bus.Sat_sticky, 0);
    model_reset();
    @(posedge CLK);
    #1;
    chk("arst_hold_ov", bus.Out_valid, 0);
    @(negedge CLK);
    RST = 1'b0;
    idle();
    idle();
    step(1, 1, 0, 0, 1024, 9);
    idle();
    idle();
    chk("post_rst_acc", bus.Valores, 9);
    chk("post_rst_ov", bus.Out_valid, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/aritmetica_pipe.md
# aritmetica_pipe

Pipelined, parametrised signed fixed-point multiply-add unit computing Valores = sat(addend + (Multip_G × Entrada_G) >>> FRAC) at one sample per clock. It generalises the combinational Constantes/Multip/Entrada arithmetic stage to configurable width and fractional precision. It adds valid qualification, saturation with status flags, and an accumulate mode that feeds back the previous result, so one instance can run a filter tap chain or a running sum. It sits between the sample source and the result sink in the filter datapath.

## Interface
- W, 24, data width (two's complement, all data ports)
- FRAC, 10, fractional bits of Multip_G; 1.0 = 2^FRAC; 1 ≤ FRAC < W
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- In_valid  in  1  sample strobe; inputs are accepted on each rising CLK edge where it is high
- Acum_en  in  1  1: addend = previous result (accumulator); 0: addend = Constantes_G
- Acum_clr  in  1  with Acum_en=1, addend forced to 0 for this sample (starts a new sum); also clears Sat_sticky
- Constantes_G  in  W  signed additive constant
- Multip_G  in  W  signed coefficient, FRAC fractional bits
- Entrada_G  in  W  signed input sample
- Valores  out  W  signed saturated result (also the accumulator register)
- Out_valid  out  1  high for exactly one cycle per accepted sample
- Sat  out  1  the result presented with this Out_valid was saturated
- Sat_sticky  out  1  set by any saturation; cleared only by RST or an accepted Acum_clr

## Operation
- Stage 1 registers the inputs, Acum_en, Acum_clr and In_valid. The data registers load only when In_valid=1.
- Stage 2: P = (Multip × Entrada), full 2W-bit signed product. Then P >>> FRAC (arithmetic shift, truncation toward −∞), registered at 2W−FRAC bits.
- Stage 3 selects the addend:
  - Acum_en=0: pipelined Constantes_G.
  - Acum_en=1, Acum_clr=0: current Valores register.
  - Acum_en=1, Acum_clr=1: 0.
- Stage 3 computes S = addend + P at 2W−FRAC+1 bits, sign-extended.
- Saturation: S > 2^(W−1)−1 gives 2^(W−1)−1. S < −2^(W−1) gives −2^(W−1). Otherwise S[W−1:0]. Sat=1 when clamped.
- Valores, Sat and Sat_sticky update only when the stage-3 valid is 1. Otherwise they hold; Sat is not forced to 0.
- Acum_en and Acum_clr are ignored when In_valid=0.
- Acum_clr with Acum_en=0: clears Sat_sticky (before OR-ing in this sample's Sat); the addend is still Constantes_G.
- Back-to-back accumulate samples chain correctly: each stage-3 add uses Valores as written on the previous edge.
- There is no backpressure; the sink must take every Out_valid pulse.

## Timing
- Sample accepted at edge t. Valores, Sat and Out_valid are valid after edge t+2 (latency 3 register stages). Throughput is 1 sample/cycle.
- Out_valid is high in cycle t+2 only. Gaps in In_valid appear as identical gaps in Out_valid.
- Reset values: Valores=0, Out_valid=0, Sat=0, Sat_sticky=0, all pipeline valids=0, pipeline data=0.
- RST mid-operation discards every in-flight sample; no Out_valid is produced for them.
- After RST deasserts, the first sample accepted at edge t still emits at t+2. In accumulate mode without Acum_clr it adds to 0.

## Test plan
- W=24, FRAC=10: C=5, M=1024, E=300, Acum_en=0 → Valores=305 (0x000131) two cycles after acceptance; Out_valid is a single 1-cycle pulse; Sat=0.
- Sign and truncation cases:
  - C=0, M=−1024, E=300 → 0xFFFED4 (−300).
  - M=1, E=1 → 0.
  - M=−1, E=1 → 0xFFFFFF (−1, floor).
- Saturation:
  - C=0x7FFFFF, M=E=0x7FFFFF → 0x7FFFFF, Sat=1, Sat_sticky=1.
  - C=0x800000, M=0x7FFFFF, E=0x800000 → 0x800000, Sat=1.
  - A following normal sample → Sat=0, Sat_sticky stays 1.
- Accumulate, back-to-back, M=1024:
  - E=100 with clr=1, en=1 → 100.
  - E=50 with en=1 → 150.
  - E=−200 with en=1 → −50.
  - en=0, C=7, M=0 → 7.
  - The accepted clr clears Sat_sticky.
- Throughput and gaps: 5000 random samples with random In_valid are checked against a reference model. The number of Out_valid pulses equals the number of accepted samples, with pulse pattern equal to In_valid delayed 2 cycles.
- Reset: RST asserted asynchronously (mid-cycle) with two samples in flight. All outputs go to 0 immediately, and no Out_valid follows for the flushed samples. After release, a sample with en=1, clr=0, M=1024, E=9 → 9.
